// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: decodes the instruction format from the
// opcode and emits a sign-extended immediate, format tag, PC and illegal flag
// through a valid/ready stage, with an optional 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SKID  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned FMT_W  = 3;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned WIDE_W = 64;

  localparam logic [FMT_W-1:0] FMT_R = 3'd0;
  localparam logic [FMT_W-1:0] FMT_I = 3'd1;
  localparam logic [FMT_W-1:0] FMT_S = 3'd2;
  localparam logic [FMT_W-1:0] FMT_B = 3'd3;
  localparam logic [FMT_W-1:0] FMT_U = 3'd4;
  localparam logic [FMT_W-1:0] FMT_J = 3'd5;
  localparam logic [FMT_W-1:0] FMT_Z = 3'd6;

  localparam logic [OPC_W-1:0] OP_LUI     = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC   = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_JAL     = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_BRANCH  = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_STORE   = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_JALR    = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LOAD    = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_OPIMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_MISCMEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OP_OPIMM32 = 7'b0011011;
  localparam logic [OPC_W-1:0] OP_SYSTEM  = 7'b1110011;
  localparam logic [OPC_W-1:0] OP_OP      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_OP32    = 7'b0111011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  logic [OPC_W-1:0]  opcode;
  logic [FMT_W-1:0]  dec_fmt;
  logic              dec_ill;
  logic [WIDE_W-1:0] imm_i;
  logic [WIDE_W-1:0] imm_s;
  logic [WIDE_W-1:0] imm_b;
  logic [WIDE_W-1:0] imm_u;
  logic [WIDE_W-1:0] imm_j;
  logic [WIDE_W-1:0] imm_z;
  entry_t            dec;

  entry_t            main_q;
  entry_t            main_d;
  logic              main_vld_q;
  logic              main_vld_d;
  entry_t            skid_q;
  entry_t            skid_d;
  logic              skid_vld_q;
  logic              skid_vld_d;
  logic              in_fire;
  logic              out_fire;
  logic [CNT_W-1:0]  cnt_q;

  assign opcode = in_inst[6:0];

  // Immediates are built at 64 bits and trimmed to XLEN, so U sign-extends for RV64.
  assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
  assign imm_z = {59'b0, in_inst[19:15]};

  // Format decode; every legal opcode ends in 2'b11, so compressed encodings fall to default.
  always_comb begin
    dec_fmt = FMT_R;
    dec_ill = 1'b0;
    case (opcode)
      OP_LUI, OP_AUIPC:                      dec_fmt = FMT_U;
      OP_JAL:                                dec_fmt = FMT_J;
      OP_BRANCH:                             dec_fmt = FMT_B;
      OP_STORE:                              dec_fmt = FMT_S;
      OP_JALR, OP_LOAD, OP_OPIMM, OP_MISCMEM: dec_fmt = FMT_I;
      OP_OPIMM32: begin
        if (XLEN == 64) dec_fmt = FMT_I;
        else            dec_ill = 1'b1;
      end
      OP_SYSTEM:                             dec_fmt = in_inst[14] ? FMT_Z : FMT_I;
      OP_OP:                                 dec_fmt = FMT_R;
      OP_OP32: begin
        if (XLEN != 64) dec_ill = 1'b1;
      end
      default:                               dec_ill = 1'b1;
    endcase
  end

  // Select the immediate for the decoded format; R and illegal entries carry zero.
  always_comb begin
    dec         = '0;
    dec.pc      = in_pc;
    dec.fmt     = dec_fmt;
    dec.illegal = dec_ill;
    case (dec_fmt)
      FMT_I:   dec.imm = imm_i[XLEN-1:0];
      FMT_S:   dec.imm = imm_s[XLEN-1:0];
      FMT_B:   dec.imm = imm_b[XLEN-1:0];
      FMT_U:   dec.imm = imm_u[XLEN-1:0];
      FMT_J:   dec.imm = imm_j[XLEN-1:0];
      FMT_Z:   dec.imm = imm_z[XLEN-1:0];
      default: dec.imm = '0;
    endcase
  end

  // Ready: registered skid-occupancy view, or pass-through of downstream ready.
  generate
    if (SKID != 0) begin : g_skid
      assign in_ready = !skid_vld_q;
    end else begin : g_noskid
      assign in_ready = !main_vld_q || out_ready;
    end
  endgenerate

  assign in_fire  = in_valid && in_ready;
  assign out_fire = main_vld_q && out_ready;

  // Occupancy next-state: head pops, skid refills head, new entry lands in head or skid.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (out_fire) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      if (!main_vld_q) begin
        main_d     = dec;
        main_vld_d = 1'b1;
      end else begin
        skid_d     = dec;
        skid_vld_d = 1'b1;
      end
    end
    if (SKID == 0) skid_vld_d = 1'b0;
  end

  // Pipeline state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Saturating count of illegal entries handed downstream; flush leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (out_fire && main_q.illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign out_valid   = main_vld_q;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_pc      = main_q.pc;
  assign out_illegal = main_q.illegal;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: four configurations share one stimulus stream
// (RV32 skid, RV32 no-skid, RV64 skid, RV32 skid with a 2-bit counter).
module tb_imm_gen_pipe;

  typedef struct packed {
    logic [63:0] imm;
    logic [63:0] pc;
    logic [2:0]  fmt;
    logic        ill;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc;

  wire [3:0]  ov;
  wire [3:0]  ir;
  wire [3:0]  oill;
  wire [2:0]  ofmt [4];
  wire [63:0] oimm [4];
  wire [63:0] opc  [4];
  wire [15:0] ocnt [4];
  wire [31:0] imm_a, pc_a, imm_b, pc_b, imm_d, pc_d;
  wire [1:0]  cnt_d;

  bit is64 [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit skid [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  int cmax [4] = '{65535, 65535, 65535, 3};

  int tests = 0;
  int fails = 0;

  ent_t mq   [4][2];
  int   occ  [4];
  int   mcnt [4];

  logic [6:0] ops [13] = '{7'h37, 7'h17, 7'h6F, 7'h63, 7'h23, 7'h67, 7'h03,
                           7'h13, 7'h0F, 7'h1B, 7'h73, 7'h33, 7'h3B};

  logic [31:0] d_inst [11] = '{32'hFFF00093, 32'hFE000EE3, 32'h800002B7, 32'h300FD073,
                               32'hFE112E23, 32'hFF9FF06F, 32'h00000033, 32'h0010809B,
                               32'h0000003B, 32'h00000073, 32'h12345037};
  logic [31:0] d_imm32 [11] = '{32'hFFFFFFFF, 32'hFFFFFFFC, 32'h80000000, 32'h0000001F,
                                32'hFFFFFFFC, 32'hFFFFFFF8, 32'h0, 32'h0,
                                32'h0, 32'h0, 32'h12345000};
  logic [2:0]  d_fmt32 [11] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd2, 3'd5, 3'd0, 3'd0, 3'd0, 3'd1, 3'd4};
  logic        d_ill32 [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [63:0] d_imm64 [11] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFF80000000,
                                64'h1F, 64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8, 64'h0,
                                64'h1, 64'h0, 64'h0, 64'h12345000};
  logic [2:0]  d_fmt64 [11] = '{3'd1, 3'd3, 3'd4, 3'd6, 3'd2, 3'd5, 3'd0, 3'd1, 3'd0, 3'd1, 3'd4};

  assign oimm[0] = {32'b0, imm_a};
  assign opc[0]  = {32'b0, pc_a};
  assign oimm[1] = {32'b0, imm_b};
  assign opc[1]  = {32'b0, pc_b};
  assign oimm[3] = {32'b0, imm_d};
  assign opc[3]  = {32'b0, pc_d};
  assign ocnt[3] = {14'b0, cnt_d};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov[0]), .out_ready(out_ready),
    .out_imm(imm_a), .out_fmt(ofmt[0]), .out_pc(pc_a), .out_illegal(oill[0]),
    .illegal_cnt(ocnt[0]));

  imm_gen_pipe #(.XLEN(32), .SKID(0), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov[1]), .out_ready(out_ready),
    .out_imm(imm_b), .out_fmt(ofmt[1]), .out_pc(pc_b), .out_illegal(oill[1]),
    .illegal_cnt(ocnt[1]));

  imm_gen_pipe #(.XLEN(64), .SKID(1), .CNT_W(16)) u_d2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(ov[2]), .out_ready(out_ready),
    .out_imm(oimm[2]), .out_fmt(ofmt[2]), .out_pc(opc[2]), .out_illegal(oill[2]),
    .illegal_cnt(ocnt[2]));

  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir[3]),
    .in_inst(in_inst), .in_pc(in_pc[31:0]), .out_valid(ov[3]), .out_ready(out_ready),
    .out_imm(imm_d), .out_fmt(ofmt[3]), .out_pc(pc_d), .out_illegal(oill[3]),
    .illegal_cnt(cnt_d));

  // Two's-complement sign extension of a 'bits'-wide field held in v.
  function automatic longint sx(input longint v, input int bits);
    if (((v >> (bits - 1)) & 64'd1) != 0) return v - (longint'(1) << bits);
    return v;
  endfunction

  // Reference decode written straight from the format table.
  function automatic ent_t ref_dec(input logic [31:0] inst, input logic [63:0] pc, input bit x64);
    ent_t e;
    logic [6:0] op;
    longint v;
    bit ill;
    op  = inst[6:0];
    v   = 0;
    ill = 1'b0;
    e   = '0;
    e.pc = x64 ? pc : {32'b0, pc[31:0]};
    if (op == 7'h37 || op == 7'h17) begin
      e.fmt = 3'd4; v = sx({inst[31:12], 12'b0}, 32);
    end else if (op == 7'h6F) begin
      e.fmt = 3'd5; v = sx({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}, 21);
    end else if (op == 7'h63) begin
      e.fmt = 3'd3; v = sx({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}, 13);
    end else if (op == 7'h23) begin
      e.fmt = 3'd2; v = sx({inst[31:25], inst[11:7]}, 12);
    end else if (op == 7'h67 || op == 7'h03 || op == 7'h13 || op == 7'h0F ||
                 (op == 7'h1B && x64) || (op == 7'h73 && !inst[14])) begin
      e.fmt = 3'd1; v = sx(inst[31:20], 12);
    end else if (op == 7'h73) begin
      e.fmt = 3'd6; v = inst[19:15];
    end else if (op == 7'h33 || (op == 7'h3B && x64)) begin
      e.fmt = 3'd0; v = 0;
    end else begin
      ill = 1'b1;
    end
    if (ill) begin
      e.fmt = 3'd0; v = 0; e.ill = 1'b1;
    end
    e.imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) < 8) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      occ[i] = 0; mcnt[i] = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({ov[i], oimm[i], ofmt[i], opc[i], oill[i], ocnt[i]} !== 146'd0) begin
        fails++;
        $display("FAIL reset_state dut%0d got v=%b imm=%h fmt=%0d pc=%h ill=%b cnt=%0d exp all zero",
                 i, ov[i], oimm[i], ofmt[i], opc[i], oill[i], ocnt[i]);
      end
      tests++;
      if (ir[i] !== 1'b1) begin
        fails++; $display("FAIL reset_in_ready dut%0d got %b exp 1", i, ir[i]);
      end
    end
  endtask

  task automatic test_decode();
    logic [63:0] eimm;
    logic [2:0]  efmt;
    logic        eill;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 11; k++) begin
      @(negedge clk);
      if (k > 0) begin
        for (int i = 0; i < 4; i++) begin
          eimm = is64[i] ? d_imm64[k-1] : {32'b0, d_imm32[k-1]};
          efmt = is64[i] ? d_fmt64[k-1] : d_fmt32[k-1];
          eill = is64[i] ? 1'b0 : d_ill32[k-1];
          tests++;
          if ({ov[i], oimm[i], ofmt[i], oill[i]} !== {1'b1, eimm, efmt, eill}) begin
            fails++;
            $display("FAIL decode dut%0d inst=%h got v=%b imm=%h fmt=%0d ill=%b exp v=1 imm=%h fmt=%0d ill=%b",
                     i, d_inst[k-1], ov[i], oimm[i], ofmt[i], oill[i], eimm, efmt, eill);
          end
          tests++;
          if (opc[i] !== (is64[i] ? 64'hABCD000000001000 + 64'(4 * (k - 1)) : 64'(32'h1000 + 4 * (k - 1)))) begin
            fails++; $display("FAIL decode_pc dut%0d got %h", i, opc[i]);
          end
          tests++;
          if (ir[i] !== 1'b1) begin
            fails++; $display("FAIL b2b_in_ready dut%0d got %b exp 1", i, ir[i]);
          end
        end
      end
      if (k < 11) begin
        in_valid = 1'b1; in_inst = d_inst[k]; in_pc = 64'hABCD000000001000 + 64'(4 * k);
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_illegal();
    logic [31:0] seq [5] = '{32'h00000000, 32'h0000007F, 32'h00000000, 32'h0000007F, 32'h00000000};
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        if (k > 0) begin
          tests++;
          if ({ov[i], oill[i], ofmt[i], oimm[i]} !== {1'b1, 1'b1, 3'd0, 64'd0}) begin
            fails++;
            $display("FAIL illegal_entry dut%0d got v=%b ill=%b fmt=%0d imm=%h exp v=1 ill=1 fmt=0 imm=0",
                     i, ov[i], oill[i], ofmt[i], oimm[i]);
          end
        end
        if (k == 3) begin
          tests++;
          if (ocnt[i] !== 16'd2) begin
            fails++; $display("FAIL illegal_cnt_two dut%0d got %0d exp 2", i, ocnt[i]);
          end
        end
      end
      in_valid = (k < 5); in_inst = (k < 5) ? seq[k % 5] : 32'h0; in_pc = 64'(k);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ocnt[i] !== ((i == 3) ? 16'd3 : 16'd5)) begin
        fails++; $display("FAIL illegal_cnt_sat dut%0d got %0d exp %0d", i, ocnt[i], (i == 3) ? 3 : 5);
      end
    end
  endtask

  task automatic test_skid();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'hFFF00093; in_pc = 64'hA0;
    @(negedge clk);
    tests++;
    if ({ov[0], opc[0], ir[0]} !== {1'b1, 64'hA0, 1'b1}) begin
      fails++; $display("FAIL skid_first dut0 got v=%b pc=%h rdy=%b exp 1 a0 1", ov[0], opc[0], ir[0]);
    end
    in_inst = 32'hFE000EE3; in_pc = 64'hB0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tests++;
      if ({ov[0], opc[0], oimm[0], ir[0]} !== {1'b1, 64'hA0, 64'hFFFFFFFF, 1'b0}) begin
        fails++; $display("FAIL skid_hold dut0 got v=%b pc=%h imm=%h rdy=%b exp 1 a0 ffffffff 0",
                          ov[0], opc[0], oimm[0], ir[0]);
      end
      tests++;
      if ({ov[1], opc[1], ir[1]} !== {1'b1, 64'hA0, 1'b0}) begin
        fails++; $display("FAIL noskid_hold dut1 got v=%b pc=%h rdy=%b exp 1 a0 0", ov[1], opc[1], ir[1]);
      end
      if (c == 0) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if ({ov[0], opc[0], oimm[0], ir[0]} !== {1'b1, 64'hB0, 64'hFFFFFFFC, 1'b1}) begin
      fails++; $display("FAIL skid_drain dut0 got v=%b pc=%h imm=%h rdy=%b exp 1 b0 fffffffc 1",
                        ov[0], opc[0], oimm[0], ir[0]);
    end
    @(negedge clk);
    tests++;
    if (ov[0] !== 1'b0) begin
      fails++; $display("FAIL skid_empty dut0 got v=%b exp 0", ov[0]);
    end
  endtask

  task automatic test_flush();
    do_reset();
    @(negedge clk);
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'h10;
    @(negedge clk);
    in_pc = 64'h14;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if ({ov[0], ir[0]} !== 2'b01) begin
      fails++; $display("FAIL flush_full dut0 got v=%b rdy=%b exp v=0 rdy=1", ov[0], ir[0]);
    end
    // Flush with one entry held while an illegal input is presented in the same cycle.
    in_valid = 1'b1; in_inst = 32'h00000013; in_pc = 64'h20;
    @(negedge clk);
    flush = 1'b1; in_inst = 32'h00000000; in_pc = 64'h24;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({ov[i], ocnt[i]} !== 17'd0) begin
          fails++; $display("FAIL flush_drop dut%0d got v=%b cnt=%0d exp 0 0", i, ov[i], ocnt[i]);
        end
      end
      @(negedge clk);
    end
    // Mid-stream reset with one illegal already counted and entries still held.
    in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 64'h30;
    @(negedge clk);
    in_inst = 32'hFFF00093; in_pc = 64'h34;
    @(negedge clk);
    out_ready = 1'b0; in_pc = 64'h38;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (ocnt[i] !== 16'd1) begin
        fails++; $display("FAIL pre_reset_cnt dut%0d got %0d exp 1", i, ocnt[i]);
      end
    end
    rst_n = 1'b0; flush = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({ov[i], oimm[i], ofmt[i], opc[i], oill[i], ocnt[i]} !== 146'd0) begin
          fails++;
          $display("FAIL midreset dut%0d got v=%b imm=%h fmt=%0d pc=%h ill=%b cnt=%0d exp all zero",
                   i, ov[i], oimm[i], ofmt[i], opc[i], oill[i], ocnt[i]);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random(input int ncyc);
    ent_t got;
    ent_t prev [4];
    bit   stall [4];
    bit   exp_ir, infire, outfire;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      stall[i] = 1'b0; prev[i] = '0;
    end
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        got = {oimm[i], opc[i], ofmt[i], oill[i]};
        tests++;
        if (ov[i] !== (occ[i] > 0)) begin
          fails++; $display("FAIL rnd_valid cyc%0d dut%0d got %b exp %b", c, i, ov[i], occ[i] > 0);
        end
        if (occ[i] > 0) begin
          tests++;
          if (got !== mq[i][0]) begin
            fails++; $display("FAIL rnd_entry cyc%0d dut%0d got %h exp %h", c, i, got, mq[i][0]);
          end
        end
        tests++;
        if (ocnt[i] !== 16'(mcnt[i])) begin
          fails++; $display("FAIL rnd_cnt cyc%0d dut%0d got %0d exp %0d", c, i, ocnt[i], mcnt[i]);
        end
        if (stall[i]) begin
          tests++;
          if (ov[i] !== 1'b1 || got !== prev[i]) begin
            fails++; $display("FAIL rnd_stable cyc%0d dut%0d got %h exp %h", c, i, got, prev[i]);
          end
        end
        prev[i] = got;
      end
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 49) == 0);
      in_inst   = rand_inst();
      in_pc     = {$urandom, $urandom};
      #1;
      for (int i = 0; i < 4; i++) begin
        exp_ir = skid[i] ? (occ[i] < 2) : (occ[i] == 0 || out_ready);
        tests++;
        if (ir[i] !== exp_ir) begin
          fails++; $display("FAIL rnd_in_ready cyc%0d dut%0d got %b exp %b", c, i, ir[i], exp_ir);
        end
        infire  = in_valid && exp_ir;
        outfire = (occ[i] > 0) && out_ready;
        stall[i] = (occ[i] > 0) && !out_ready && !flush;
        if (outfire && mq[i][0].ill && mcnt[i] < cmax[i]) mcnt[i]++;
        if (flush) begin
          occ[i] = 0;
        end else begin
          if (outfire) begin
            mq[i][0] = mq[i][1]; occ[i]--;
          end
          if (infire) begin
            mq[i][occ[i]] = ref_dec(in_inst, in_pc, is64[i]); occ[i]++;
          end
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 64'h0;
    test_reset();
    test_decode();
    test_illegal();
    test_skid();
    test_flush();
    test_random(3000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
